// File: rtl/md_unit_if.sv
// Execute-stage handshake between the hazard/decode side and the RV32M multiply/divide unit.
// The master side drives the operation and flush; the slave side (md_unit) returns stall, done and result.
interface md_unit_if #(parameter int XLEN = 32);
  logic            StartE;
  logic [2:0]      MdOpE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            FlushE;
  logic            MdBusyE;
  logic            MdDoneE;
  logic [XLEN-1:0] MdResultE;

  modport master (
    output StartE, MdOpE, SrcAE, SrcBE, FlushE,
    input  MdBusyE, MdDoneE, MdResultE
  );

  modport slave (
    input  StartE, MdOpE, SrcAE, SrcBE, FlushE,
    output MdBusyE, MdDoneE, MdResultE
  );
endinterface

// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiplier and 32-step restoring divider
// sharing one counter and one control FSM; raises a combinational stall while iterating.
module md_unit #(parameter int XLEN = 32) (
  input logic       clk,
  input logic       reset,
  md_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state, nxt;
  logic [4:0]        cnt;
  logic [1:0]        op;
  logic              sign;
  logic [XLEN-1:0]   a;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   result;
  logic [2*XLEN-1:0] prod;

  logic              signA, signB, sA, sB, startSign, start, divZero, divOvf, fast;
  logic [XLEN-1:0]   absA, absB, fastRes;

  // Decode a new instruction: operand signedness, magnitudes, result sign and the fast paths.
  always_comb begin
    signA     = (bus.MdOpE == 3'b001) || (bus.MdOpE == 3'b010) || (bus.MdOpE[2] && !bus.MdOpE[0]);
    signB     = (bus.MdOpE == 3'b001) || (bus.MdOpE[2] && !bus.MdOpE[0]);
    sA        = signA && bus.SrcAE[XLEN-1];
    sB        = signB && bus.SrcBE[XLEN-1];
    absA      = sA ? -bus.SrcAE : bus.SrcAE;
    absB      = sB ? -bus.SrcBE : bus.SrcBE;
    startSign = (bus.MdOpE == 3'b110) ? sA : (sA ^ sB);
    start     = (state == IDLE) && bus.StartE && !bus.FlushE;
    divZero   = bus.MdOpE[2] && (bus.SrcBE == '0);
    divOvf    = bus.MdOpE[2] && !bus.MdOpE[0] &&
                (bus.SrcAE == {1'b1, {(XLEN-1){1'b0}}}) && (bus.SrcBE == {XLEN{1'b1}});
    fast      = divZero || divOvf;
    // Signed overflow quotient equals the dividend itself, so SrcAE doubles as that result.
    fastRes   = divZero ? (bus.MdOpE[1] ? bus.SrcAE : {XLEN{1'b1}})
                        : (bus.MdOpE[1] ? '0 : bus.SrcAE);
  end

  logic [XLEN:0]     mulSum;
  logic [2*XLEN-1:0] mulNext, mulFinal;
  logic [XLEN-1:0]   mulRes;
  logic [XLEN:0]     shifted, trial;
  logic              fits, lastIter;
  logic [XLEN-1:0]   remNext, quoNext, divMag, divRes;

  // One iteration of each datapath, plus the signed fix-up applied on the final step.
  always_comb begin
    lastIter = (cnt == 5'd31);
    mulSum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, a} : '0);
    mulNext  = {mulSum, prod[XLEN-1:1]};
    mulFinal = sign ? -mulNext : mulNext;
    mulRes   = (op == 2'b00) ? mulFinal[XLEN-1:0] : mulFinal[2*XLEN-1:XLEN];
    // The partial remainder is always below the divisor, so 32 stored bits plus the borrow suffice.
    shifted  = {rem, quo[XLEN-1]};
    trial    = shifted - {1'b0, a};
    fits     = !trial[XLEN];
    remNext  = fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    quoNext  = {quo[XLEN-2:0], fits};
    divMag   = op[1] ? remNext : quoNext;
    divRes   = sign ? -divMag : divMag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next-state logic; a flush always returns to IDLE and beats a start.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = fast ? DONE : (bus.MdOpE[2] ? DIV : MUL);
      MUL:     if (lastIter) nxt = DONE;
      DIV:     if (lastIter) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (bus.FlushE) nxt = IDLE;
  end

  // Datapath registers; the multiplier keeps its operand in the low half of the product register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      op     <= '0;
      sign   <= 1'b0;
      a      <= '0;
      quo    <= '0;
      rem    <= '0;
      prod   <= '0;
      result <= '0;
    end else if (start) begin
      cnt  <= '0;
      op   <= bus.MdOpE[1:0];
      sign <= startSign;
      a    <= bus.MdOpE[2] ? absB : absA;
      quo  <= absA;
      rem  <= '0;
      prod <= {{XLEN{1'b0}}, absB};
      if (fast) result <= fastRes;
    end else if (state == MUL && !bus.FlushE) begin
      prod <= mulNext;
      cnt  <= cnt + 5'd1;
      if (lastIter) result <= mulRes;
    end else if (state == DIV && !bus.FlushE) begin
      rem <= remNext;
      quo <= quoNext;
      cnt <= cnt + 5'd1;
      if (lastIter) result <= divRes;
    end
  end

  assign bus.MdBusyE   = !reset && ((start && !fast) || state == MUL || state == DIV);
  assign bus.MdDoneE   = (state == DONE);
  assign bus.MdResultE = result;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed RV32M cases, flush/reset aborts and randomized ops
// checked every cycle against a cycle-budget and arithmetic reference model.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          checks = 0;
  int          errors = 0;
  int          busyCycles = 0;
  int          doneCycles = 0;
  bit          cmpOn = 1'b0;
  logic        expBusy = 1'b0;
  logic        expDone = 1'b0;
  logic [31:0] expRes = '0;

  md_unit_if #(.XLEN(32)) bus();

  md_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions, using wide native integer math.
  function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int          ia, ib, q;
    longint      la, lb, ulb;
    logic [63:0] uu, ss, su;
    ia  = a;
    ib  = b;
    la  = ia;
    lb  = ib;
    ulb = {32'b0, b};
    uu  = {32'b0, a} * {32'b0, b};
    ss  = la * lb;
    su  = la * ulb;
    case (op)
      3'd0: return uu[31:0];
      3'd1: return ss[63:32];
      3'd2: return su[63:32];
      3'd3: return uu[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = ia / ib;
        return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = ia % ib;
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit isFast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic flush);
    bus.StartE = start;
    bus.MdOpE  = op;
    bus.SrcAE  = a;
    bus.SrcBE  = b;
    bus.FlushE = flush;
  endtask

  // Holds StartE like a stalled pipeline: 33 busy cycles then one done cycle, or done right after E0 on a fast path.
  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int flushAt, input bit pin, input logic [31:0] lit);
    logic [31:0] r;
    bit          fast;
    r    = refModel(op, a, b);
    fast = isFast(op, a, b);
    if (pin) checkOutput("model_pin", r, lit);
    applyStimulus(1'b1, op, a, b, 1'b0);
    expDone = 1'b0;
    expBusy = !fast;
    tick();
    if (!fast) begin
      for (int k = 0; k < 32; k++) begin
        if (k == flushAt) begin
          bus.FlushE = 1'b1;
          tick();
          applyStimulus(1'b0, op, a, b, 1'b0);
          expBusy = 1'b0;
          return;
        end
        tick();
      end
    end
    expBusy = 1'b0;
    expDone = 1'b1;
    expRes  = r;
    if (pin) checkOutput("result_lit", bus.MdResultE, lit);
    tick();
    bus.StartE = 1'b0;
    expDone    = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cmpOn) begin
      if (bus.MdBusyE) busyCycles++;
      if (bus.MdDoneE) doneCycles++;
      checkOutput("busy",   {31'b0, bus.MdBusyE}, {31'b0, expBusy});
      checkOutput("done",   {31'b0, bus.MdDoneE}, {31'b0, expDone});
      checkOutput("result", bus.MdResultE, expRes);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int b0, d0, flushAt;
    logic [2:0] rop;
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    checkOutput("reset_busy",   {31'b0, bus.MdBusyE}, 32'h0);
    checkOutput("reset_done",   {31'b0, bus.MdDoneE}, 32'h0);
    checkOutput("reset_result", bus.MdResultE, 32'h0);
    reset = 1'b0;
    cmpOn = 1'b1;
    tick();

    b0 = busyCycles;
    d0 = doneCycles;
    runOp(3'd0, 32'd7, 32'hFFFF_FFFD, -1, 1'b1, 32'hFFFF_FFEB);
    checkOutput("mul_busy_cycles", 32'(busyCycles - b0), 32'd33);
    checkOutput("mul_done_cycles", 32'(doneCycles - d0), 32'd1);
    runOp(3'd1, 32'h8000_0000, 32'h8000_0000, -1, 1'b1, 32'h4000_0000);
    runOp(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b1, 32'hFFFF_FFFE);
    runOp(3'd2, 32'hFFFF_FFFF, 32'd2,         -1, 1'b1, 32'hFFFF_FFFF);
    runOp(3'd5, 32'd100, 32'd7, -1, 1'b1, 32'd14);
    runOp(3'd7, 32'd100, 32'd7, -1, 1'b1, 32'd2);
    runOp(3'd4, 32'hFFFF_FFF9, 32'd2, -1, 1'b1, 32'hFFFF_FFFD);
    runOp(3'd6, 32'hFFFF_FFF9, 32'd2, -1, 1'b1, 32'hFFFF_FFFF);

    b0 = busyCycles;
    runOp(3'd4, 32'd5, 32'd0, -1, 1'b1, 32'hFFFF_FFFF);
    runOp(3'd6, 32'd5, 32'd0, -1, 1'b1, 32'd5);
    runOp(3'd5, 32'd5, 32'd0, -1, 1'b1, 32'hFFFF_FFFF);
    runOp(3'd7, 32'd5, 32'd0, -1, 1'b1, 32'd5);
    runOp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b1, 32'h8000_0000);
    runOp(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b1, 32'h0);
    checkOutput("fast_busy_cycles", 32'(busyCycles - b0), 32'd0);

    d0 = doneCycles;
    runOp(3'd4, 32'd1000, 32'd3, 10, 1'b0, 32'h0);
    tick();
    checkOutput("flush_no_done", 32'(doneCycles - d0), 32'd0);
    runOp(3'd0, 32'd3, 32'd4, -1, 1'b1, 32'd12);

    applyStimulus(1'b1, 3'd5, 32'd9, 32'd3, 1'b1);
    expBusy = 1'b0;
    expDone = 1'b0;
    tick();
    applyStimulus(1'b0, 3'd5, 32'd9, 32'd3, 1'b0);
    tick();

    applyStimulus(1'b1, 3'd0, 32'd5, 32'd6, 1'b0);
    expBusy = 1'b1;
    tick();
    repeat (5) tick();
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_busy",   {31'b0, bus.MdBusyE}, 32'h0);
    checkOutput("async_done",   {31'b0, bus.MdDoneE}, 32'h0);
    checkOutput("async_result", bus.MdResultE, 32'h0);
    expBusy = 1'b0;
    expDone = 1'b0;
    expRes  = 32'h0;
    tick();
    tick();
    bus.StartE = 1'b0;
    reset      = 1'b0;
    tick();

    for (int i = 0; i < 40; i++) begin
      rop     = 3'($urandom_range(0, 7));
      flushAt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : -1;
      runOp(rop, pickOperand(), pickOperand(), flushAt, 1'b0, 32'h0);
      if ($urandom_range(0, 3) == 0) begin
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'($urandom_range(0, 1)));
        expBusy = 1'b0;
        expDone = 1'b0;
        tick();
        bus.FlushE = 1'b0;
      end
    end

    runOp(3'd1, 32'hFFFF_FFFE, 32'd3, -1, 1'b1, 32'hFFFF_FFFF);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
